// File: rtl/id_stall_bubble_ctrl_if.sv
// Fetch-to-decode handshake bundle between fetch, the hazard comparator and the IF/ID stall controller.
// The master side drives fetch/control inputs; the slave side (the controller) drives decode-facing outputs.
interface id_stall_bubble_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [15:0]      inst_fetch;
  logic [15:0]      pc_fetch;
  logic             sendNOP;
  logic             flush;
  logic [15:0]      inst_id;
  logic [15:0]      pc_id;
  logic             pc_write_en;
  logic             NOPEx;
  logic             NOPMem;
  logic             NOPWB;
  logic             stall_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output inst_fetch, pc_fetch, sendNOP, flush,
    input  inst_id, pc_id, pc_write_en, NOPEx, NOPMem, NOPWB, stall_err, stall_cycles
  );

  modport slave (
    input  inst_fetch, pc_fetch, sendNOP, flush,
    output inst_id, pc_id, pc_write_en, NOPEx, NOPMem, NOPWB, stall_err, stall_cycles
  );
endinterface

// File: rtl/id_stall_bubble_ctrl.sv
// IF/ID pipeline register with stall/bubble injection, branch squash, per-stage valid flags
// and stall statistics (saturating stall counter, sticky stuck-stall flag).
module id_stall_bubble_ctrl #(
  parameter logic [15:0] NOP_INST  = 16'h0800,
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst,
  id_stall_bubble_ctrl_if.slave bus
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_STUCK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             stall_err_q, stall_err_d;

  logic [15:0]      inst_id_q, inst_id_d;
  logic [15:0]      pc_id_q, pc_id_d;
  logic             id_valid_q, id_valid_d;
  logic             nop_ex_q, nop_ex_d;
  logic             nop_mem_q, nop_wb_q;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic             stall;

  // sendNOP is active low; a flush in the same cycle overrides the stall
  assign stall           = ~bus.sendNOP & ~bus.flush;
  assign bus.pc_write_en = rst | bus.flush | bus.sendNOP;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      run_len_q   <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      stall_err_q <= stall_err_d;
    end
  end

  // FSM next state: track length of the current stall run
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    case (state_q)
      S_RUN: begin
        if (stall) begin
          state_d   = S_STALL;
          run_len_d = RUN_W'(1);
        end
      end
      S_STALL: begin
        if (!stall) begin
          state_d   = S_RUN;
          run_len_d = '0;
        end else if (run_len_q >= RUN_W'(MAX_STALL)) begin
          state_d = S_STUCK;
        end else begin
          run_len_d = run_len_q + RUN_W'(1);
        end
      end
      S_STUCK: begin
        if (!stall) begin
          state_d   = S_RUN;
          run_len_d = '0;
        end
      end
      default: begin
        state_d   = S_RUN;
        run_len_d = '0;
      end
    endcase
  end

  // FSM output: stuck flag is sticky until reset
  always_comb begin
    stall_err_d = stall_err_q | (state_d == S_STUCK);
  end

  // IF/ID register and bubble tracking, priority flush > stall > advance
  always_comb begin
    inst_id_d      = inst_id_q;
    pc_id_d        = pc_id_q;
    id_valid_d     = id_valid_q;
    nop_ex_d       = 1'b0;
    stall_cycles_d = stall_cycles_q;
    if (bus.flush) begin
      inst_id_d  = NOP_INST;
      pc_id_d    = bus.pc_fetch;
      id_valid_d = 1'b0;
    end else if (stall) begin
      if (stall_cycles_q != {CNT_W{1'b1}}) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
    end else begin
      inst_id_d  = bus.inst_fetch;
      pc_id_d    = bus.pc_fetch;
      id_valid_d = (bus.inst_fetch != NOP_INST);
      nop_ex_d   = id_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_id_q      <= NOP_INST;
      pc_id_q        <= '0;
      id_valid_q     <= 1'b0;
      nop_ex_q       <= 1'b0;
      nop_mem_q      <= 1'b0;
      nop_wb_q       <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      inst_id_q      <= inst_id_d;
      pc_id_q        <= pc_id_d;
      id_valid_q     <= id_valid_d;
      nop_ex_q       <= nop_ex_d;
      nop_mem_q      <= nop_ex_q;
      nop_wb_q       <= nop_mem_q;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.inst_id      = inst_id_q;
  assign bus.pc_id        = pc_id_q;
  assign bus.NOPEx        = nop_ex_q;
  assign bus.NOPMem       = nop_mem_q;
  assign bus.NOPWB        = nop_wb_q;
  assign bus.stall_err    = stall_err_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_stall_bubble_ctrl.sv
// Directed bench for id_stall_bubble_ctrl: vector table for streaming/stall/flush, plus
// hand sequences for the stuck-stall flag, reset mid-stall and counter saturation.
module tb_id_stall_bubble_ctrl;

  logic clk;
  logic rst;
  logic sat_rst;

  int n_checks;
  int n_fail;

  id_stall_bubble_ctrl_if #(.CNT_W(16)) dut_if ();
  id_stall_bubble_ctrl_if #(.CNT_W(3))  sat_if ();

  id_stall_bubble_ctrl #(.NOP_INST(16'h0800), .MAX_STALL(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  id_stall_bubble_ctrl #(.NOP_INST(16'h0800), .MAX_STALL(8), .CNT_W(3)) u_sat (
    .clk (clk),
    .rst (sat_rst),
    .bus (sat_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] inst_f;
    logic [15:0] pc_f;
    logic        snop;
    logic        flush;
    logic [15:0] e_inst;
    logic [15:0] e_pc;
    logic        e_pcwe;
    logic        e_ex;
    logic        e_mem;
    logic        e_wb;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int unsigned NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs on the falling edge, then sample #1 after the next rising edge
  task automatic drive(input logic r, input logic [15:0] i, input logic [15:0] p,
                       input logic s, input logic f);
    @(negedge clk);
    rst                = r;
    dut_if.inst_fetch  = i;
    dut_if.pc_fetch    = p;
    dut_if.sendNOP     = s;
    dut_if.flush       = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst               = 1'b1;
    dut_if.inst_fetch = 16'h0000;
    dut_if.pc_fetch   = 16'h0000;
    dut_if.sendNOP    = 1'b1;
    dut_if.flush      = 1'b0;
    sat_rst           = 1'b1;
    sat_if.inst_fetch = 16'h0000;
    sat_if.pc_fetch   = 16'h0000;
    sat_if.sendNOP    = 1'b1;
    sat_if.flush      = 1'b0;

    //           rst   inst_f    pc_f      snop  flush  e_inst    e_pc      pcwe  ex    mem   wb    err   cnt
    vecs[0]  = '{1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0,  16'h0800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 16'h0123, 16'h0002, 1'b1, 1'b0,  16'h0123, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 16'h1123, 16'h0004, 1'b1, 1'b0,  16'h1123, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 16'h2123, 16'h0006, 1'b1, 1'b0,  16'h2123, 16'h0006, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 16'h4123, 16'h0008, 1'b1, 1'b0,  16'h4123, 16'h0008, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    // two-cycle stall on 4123
    vecs[5]  = '{1'b0, 16'h5123, 16'h000A, 1'b0, 1'b0,  16'h4123, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[6]  = '{1'b0, 16'h5123, 16'h000A, 1'b0, 1'b0,  16'h4123, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 16'h5123, 16'h000A, 1'b1, 1'b0,  16'h5123, 16'h000A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[8]  = '{1'b0, 16'h6123, 16'h000C, 1'b1, 1'b0,  16'h6123, 16'h000C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
    vecs[9]  = '{1'b0, 16'h7123, 16'h000E, 1'b1, 1'b0,  16'h7123, 16'h000E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
    // flush with a simultaneous stall request: flush wins
    vecs[10] = '{1'b0, 16'h8123, 16'h0010, 1'b0, 1'b1,  16'h0800, 16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
    vecs[11] = '{1'b0, 16'h9123, 16'h0012, 1'b1, 1'b0,  16'h9123, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    // fetched NOP propagates as a bubble
    vecs[12] = '{1'b0, 16'h0800, 16'h0014, 1'b1, 1'b0,  16'h0800, 16'h0014, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[13] = '{1'b0, 16'hA123, 16'h0016, 1'b1, 1'b0,  16'hA123, 16'h0016, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    vecs[14] = '{1'b0, 16'hB123, 16'h0018, 1'b1, 1'b0,  16'hB123, 16'h0018, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].rst, vecs[i].inst_f, vecs[i].pc_f, vecs[i].snop, vecs[i].flush);
      chk($sformatf("v%0d inst_id", i),      dut_if.inst_id,              vecs[i].e_inst);
      chk($sformatf("v%0d pc_id", i),        dut_if.pc_id,                vecs[i].e_pc);
      chk($sformatf("v%0d pc_write_en", i),  16'(dut_if.pc_write_en),     16'(vecs[i].e_pcwe));
      chk($sformatf("v%0d NOPEx", i),        16'(dut_if.NOPEx),           16'(vecs[i].e_ex));
      chk($sformatf("v%0d NOPMem", i),       16'(dut_if.NOPMem),          16'(vecs[i].e_mem));
      chk($sformatf("v%0d NOPWB", i),        16'(dut_if.NOPWB),           16'(vecs[i].e_wb));
      chk($sformatf("v%0d stall_err", i),    16'(dut_if.stall_err),       16'(vecs[i].e_err));
      chk($sformatf("v%0d stall_cycles", i), dut_if.stall_cycles,         vecs[i].e_cnt);
    end

    // Stuck stall: nine consecutive stall cycles with MAX_STALL=8
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 16'hC123, 16'h001A, 1'b0, 1'b0);
      chk($sformatf("stuck k%0d inst_id", k),      dut_if.inst_id,          16'hB123);
      chk($sformatf("stuck k%0d pc_write_en", k),  16'(dut_if.pc_write_en), 16'd0);
      chk($sformatf("stuck k%0d NOPEx", k),        16'(dut_if.NOPEx),       16'd0);
      chk($sformatf("stuck k%0d stall_cycles", k), dut_if.stall_cycles,     16'(2 + k));
      chk($sformatf("stuck k%0d stall_err", k),    16'(dut_if.stall_err),   (k == 9) ? 16'd1 : 16'd0);
      if (k >= 3) chk($sformatf("stuck k%0d NOPWB", k), 16'(dut_if.NOPWB), 16'd0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'hC123, 16'h001A, 1'b1, 1'b0);
      chk($sformatf("release k%0d inst_id", k),   dut_if.inst_id,        16'hC123);
      chk($sformatf("release k%0d stall_err", k), 16'(dut_if.stall_err), 16'd1);
      chk($sformatf("release k%0d NOPEx", k),     16'(dut_if.NOPEx),     16'd1);
    end

    // Reset on the second cycle of a stall
    drive(1'b0, 16'hD123, 16'h001C, 1'b0, 1'b0);
    chk("midstall s1 inst_id",      dut_if.inst_id,      16'hC123);
    chk("midstall s1 stall_cycles", dut_if.stall_cycles, 16'd12);
    drive(1'b1, 16'hD123, 16'h001C, 1'b0, 1'b0);
    chk("midstall rst inst_id",      dut_if.inst_id,          16'h0800);
    chk("midstall rst pc_id",        dut_if.pc_id,            16'h0000);
    chk("midstall rst pc_write_en",  16'(dut_if.pc_write_en), 16'd1);
    chk("midstall rst NOPEx",        16'(dut_if.NOPEx),       16'd0);
    chk("midstall rst NOPMem",       16'(dut_if.NOPMem),      16'd0);
    chk("midstall rst NOPWB",        16'(dut_if.NOPWB),       16'd0);
    chk("midstall rst stall_err",    16'(dut_if.stall_err),   16'd0);
    chk("midstall rst stall_cycles", dut_if.stall_cycles,     16'd0);
    // A fresh run of exactly MAX_STALL cycles must not flag: run length restarted from RUN
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 16'hD123, 16'h001C, 1'b0, 1'b0);
      chk($sformatf("postrst k%0d inst_id", k),      dut_if.inst_id,        16'h0800);
      chk($sformatf("postrst k%0d stall_cycles", k), dut_if.stall_cycles,   16'(k));
      chk($sformatf("postrst k%0d stall_err", k),    16'(dut_if.stall_err), 16'd0);
    end
    drive(1'b0, 16'hD123, 16'h001C, 1'b1, 1'b0);
    chk("postrst release inst_id", dut_if.inst_id, 16'hD123);
    chk("postrst release pc_id",   dut_if.pc_id,   16'h001C);

    // Saturation on the narrow-counter instance (CNT_W=3, max 7)
    @(negedge clk);
    sat_rst        = 1'b0;
    sat_if.sendNOP = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat k%0d stall_cycles", k), 16'(sat_if.stall_cycles), (k < 7) ? 16'(k) : 16'd7);
    end
    @(negedge clk);
    sat_if.sendNOP = 1'b1;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
